// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-packed-BCD converter (shift-and-add-3), one bit per clock.
// Feeds the seven-segment driver; result and overflow are held between conversions.
module bin2bcd_seq #(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BIN_WIDTH-1:0]    bin_in,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [4*DIGITS-1:0]     bcd_out,
    output logic                    overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    function automatic logic [63:0] max_value(input int digits);
        logic [63:0] m;
        m = 64'd1;
        for (int i = 0; i < digits; i++) begin
            m = m * 64'd10;
        end
        return m - 64'd1;
    endfunction

    localparam logic [63:0]      MAX_VAL = max_value(DIGITS);
    localparam logic [BCD_W-1:0] NINES   = {DIGITS{4'h9}};

    // All nibbles are corrected in parallel from their pre-shift values.
    function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    logic [1:0]           state;
    logic [BIN_WIDTH-1:0] bin_sr;
    logic [BCD_W-1:0]     scratch;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 ovf_pend;

    logic [BCD_W-1:0]     scratch_adj;
    logic [BCD_W-1:0]     scratch_nxt;
    logic [BIN_WIDTH-1:0] bin_sr_nxt;

    // Carry out of the top nibble is dropped; only overflow inputs reach it.
    always_comb begin
        scratch_adj = add3_nibbles(scratch);
        scratch_nxt = {scratch_adj[BCD_W-2:0], bin_sr[BIN_WIDTH-1]};
        bin_sr_nxt  = {bin_sr[BIN_WIDTH-2:0], 1'b0};
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bin_sr   <= '0;
            scratch  <= '0;
            bit_cnt  <= '0;
            ovf_pend <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= SHIFT;
                        bin_sr   <= bin_in;
                        scratch  <= '0;
                        bit_cnt  <= CNT_W'(BIN_WIDTH);
                        // Range check is taken on the value latched here, not the live input.
                        ovf_pend <= (64'(bin_in) > MAX_VAL);
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_nxt;
                    bin_sr  <= bin_sr_nxt;
                    bit_cnt <= bit_cnt - CNT_W'(1);
                    if (bit_cnt == CNT_W'(1)) begin
                        state    <= DONE;
                        bcd_out  <= ovf_pend ? NINES : scratch_nxt;
                        overflow <= ovf_pend;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: driver pushes expected results, monitor checks outputs each cycle.
module tb_bin2bcd_seq;

    localparam int BIN_WIDTH = 14;
    localparam int DIGITS    = 4;
    localparam int LAT       = BIN_WIDTH + 1;

    logic                 clk;
    logic                 rst;
    logic [BIN_WIDTH-1:0] bin_in;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [4*DIGITS-1:0]  bcd_out;
    logic                 overflow;

    bin2bcd_seq #(.BIN_WIDTH(BIN_WIDTH), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .bin_in(bin_in), .start(start),
        .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
    );

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        last;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Decimal digits by plain division; out-of-range values saturate to all nines.
    function automatic exp_t model(input int v, input int acc);
        exp_t e;
        int   p;
        e.acc = acc;
        e.ovf = (v > 9999);
        e.bcd = 16'h9999;
        if (!e.ovf) begin
            p = 1;
            for (int i = 0; i < DIGITS; i++) begin
                e.bcd[4*i +: 4] = 4'((v / p) % 10);
                p = p * 10;
            end
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: the head of the scoreboard defines the expected busy window and done cycle.
    always @(negedge clk) begin
        if (!rst) begin
            logic exp_busy, exp_done;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            if (sb.size() > 0) begin
                exp_busy = (cyc >= sb[0].acc) && (cyc < sb[0].acc + BIN_WIDTH);
                exp_done = (cyc == sb[0].acc + BIN_WIDTH);
            end
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            if (done && sb.size() > 0) begin
                last = sb.pop_front();
            end
            chk("bcd_out", 32'(bcd_out), 32'(last.bcd));
            chk("overflow", 32'(overflow), 32'(last.ovf));
        end
    end

    task automatic issue(input int v);
        bin_in = BIN_WIDTH'(v);
        start  = 1'b1;
        sb.push_back(model(v, cyc + 1));
    endtask

    task automatic run_conv(input int v, input int extra);
        issue(v);
        @(negedge clk);
        start  = 1'b0;
        bin_in = BIN_WIDTH'($urandom_range(0, 16383));
        repeat (LAT - 1 + extra) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        last  = model(0, 0);
        rst   = 1'b1;
        start = 1'b0;
        bin_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_bcd", 32'(bcd_out), 32'd0);
        chk("reset_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_conv(0, 2);
        // Live input changes during busy must not affect the latched value.
        issue(1234);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        bin_in = 14'd55;
        repeat (LAT - 4 + 1) @(negedge clk);

        run_conv(9999, 1);
        run_conv(10000, 1);
        run_conv(16383, 0);
        run_conv(7, 3);

        // Start pulses while busy are ignored.
        issue(42);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; bin_in = 14'd77;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; bin_in = 14'd88;
        @(negedge clk);
        start = 1'b0;
        repeat (LAT - 10 + 3) @(negedge clk);
        drain();

        // Start held high: back-to-back conversions, operand changed in the done cycle.
        issue(509);
        repeat (LAT) @(negedge clk);
        issue(8);
        repeat (LAT) @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        drain();

        run_conv(42, 1);
        // Asynchronous reset mid-conversion discards the result.
        issue(9876);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd", 32'(bcd_out), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        sb.delete();
        last = model(0, 0);
        @(negedge clk);
        rst = 1'b0;
        run_conv(300, 1);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) run_conv(int'($urandom_range(10000, 16383)), int'($urandom_range(0, 2)));
            else run_conv(int'($urandom_range(0, 9999)), int'($urandom_range(0, 2)));
        end
        drain();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
